// File: rtl/isa_pkg.sv
// ISA definitions for the 9-bit instruction word: op classes, opType codes,
// field positions and the shared encode/legality helpers.
package isa_pkg;

    localparam int ISA_IW = 9;

    typedef enum logic [2:0] {
        CLS_RALU  = 3'd0,
        CLS_BEQ   = 3'd1,
        CLS_SRL   = 3'd2,
        CLS_SLL   = 3'd3,
        CLS_LOAD  = 3'd4,
        CLS_STORE = 3'd5,
        CLS_JUMP  = 3'd6,
        CLS_ITYPE = 3'd7
    } op_class_e;

    localparam logic [1:0] OPT_ADD  = 2'd0;
    localparam logic [1:0] OPT_XOR  = 2'd1;
    localparam logic [1:0] OPT_XORR = 2'd2;
    localparam logic [1:0] OPT_AND  = 2'd3;
    localparam logic [1:0] OPT_ADDI = 2'd0;
    localparam logic [1:0] OPT_SUBI = 2'd1;
    localparam logic [1:0] OPT_SWAP = 2'd2;

    localparam int CLS_MSB  = 8;
    localparam int CLS_LSB  = 6;
    localparam int TYP_MSB  = 5;
    localparam int TYP_LSB  = 4;
    localparam int OPN_MSB  = 5;
    localparam int SOPN_MSB = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FULL = 2'd2
    } enc_state_e;

    function automatic logic has_type_field(input logic [2:0] cls);
        return (cls == CLS_RALU) || (cls == CLS_ITYPE);
    endfunction

    function automatic logic [ISA_IW-1:0] encode_word(input logic [2:0] cls,
                                                      input logic [1:0] typ,
                                                      input logic [5:0] opnd);
        logic [ISA_IW-1:0] w;
        w = '0;
        w[CLS_MSB:CLS_LSB] = cls;
        if (has_type_field(cls)) begin
            w[TYP_MSB:TYP_LSB] = typ;
            w[SOPN_MSB:0]      = opnd[SOPN_MSB:0];
        end else begin
            w[OPN_MSB:0] = opnd;
        end
        return w;
    endfunction

    // I-type opType 11 is unassigned; JUMP carries no operand.
    function automatic logic is_illegal(input logic [2:0] cls,
                                        input logic [1:0] typ,
                                        input logic [5:0] opnd);
        return ((cls == CLS_ITYPE) && (typ == 2'b11)) ||
               ((cls == CLS_JUMP) && (opnd != 6'd0));
    endfunction

endpackage

// File: rtl/instr_pack.sv
// Combinational packer: request fields to a 9-bit word plus illegal flag.
// The illegal flag is only produced when ENC_ILLEGAL_CHECK_EN is defined.
module instr_pack
    import isa_pkg::*;
(
    input  logic [2:0]        req_class,
    input  logic [1:0]        req_type,
    input  logic [5:0]        req_operand,
    output logic [ISA_IW-1:0] word,
    output logic              illegal
);

    // Word formation and legality classification.
    always_comb begin
        word = encode_word(req_class, req_type, req_operand);
`ifdef ENC_ILLEGAL_CHECK_EN
        illegal = is_illegal(req_class, req_type, req_operand);
`else
        illegal = 1'b0;
`endif
    end

endmodule

// File: rtl/instr_encoder.sv
// Streams encoded instruction words into instruction memory at consecutive
// addresses; optional request legality check under ENC_ILLEGAL_CHECK_EN.
module instr_encoder
    import isa_pkg::*;
#(
    parameter int IW        = ISA_IW,
    parameter int PROG_AW   = 8,
    parameter int BASE_ADDR = 0,
    parameter int DEPTH     = 256
) (
    input  logic               Clk,
    input  logic               Reset_n,
    input  logic               start,
    input  logic               stop,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [2:0]         req_class,
    input  logic [1:0]         req_type,
    input  logic [5:0]         req_operand,
    output logic               im_we,
    output logic [PROG_AW-1:0] im_addr,
    output logic [IW-1:0]      im_wdata,
    output logic [PROG_AW:0]   count,
    output logic               full,
    output logic               err,
    output logic               done
);

    localparam int CNT_W = PROG_AW + 1;

    enc_state_e         state_r;
    enc_state_e         state_nxt_s;
    logic [PROG_AW-1:0] addr_r;
    logic [CNT_W-1:0]   count_r;
    logic               im_we_r;
    logic [PROG_AW-1:0] im_addr_r;
    logic [IW-1:0]      im_wdata_r;
    logic               full_r;
    logic               err_r;
    logic               done_r;

    logic               ready_s;
    logic               accept_s;
    logic               write_s;
    logic               last_s;
    logic               restart_s;
    logic               end_s;
    logic [ISA_IW-1:0]  word_s;
    logic               illegal_s;

    instr_pack u_pack (
        .req_class   (req_class),
        .req_type    (req_type),
        .req_operand (req_operand),
        .word        (word_s),
        .illegal     (illegal_s)
    );

    // State register.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state and handshake decode; start takes priority over stop.
    always_comb begin
        state_nxt_s = state_r;
        ready_s     = 1'b0;
        accept_s    = 1'b0;
        write_s     = 1'b0;
        last_s      = 1'b0;
        restart_s   = 1'b0;
        end_s       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    restart_s   = 1'b1;
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                ready_s  = !start && !stop;
                accept_s = req_valid && ready_s;
                write_s  = accept_s && !illegal_s;
                last_s   = write_s && (count_r == CNT_W'(DEPTH - 1));
                if (start) begin
                    restart_s   = 1'b1;
                    state_nxt_s = ST_RUN;
                end else if (stop) begin
                    end_s       = 1'b1;
                    state_nxt_s = ST_IDLE;
                end else if (last_s) begin
                    state_nxt_s = ST_FULL;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_FULL: begin
                if (start) begin
                    restart_s   = 1'b1;
                    state_nxt_s = ST_RUN;
                end else if (stop) begin
                    end_s       = 1'b1;
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_FULL;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Write port, address/count tracking and status flags.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            addr_r     <= PROG_AW'(BASE_ADDR);
            count_r    <= '0;
            im_we_r    <= 1'b0;
            im_addr_r  <= '0;
            im_wdata_r <= '0;
            full_r     <= 1'b0;
            err_r      <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            im_we_r <= write_s;
            done_r  <= end_s;
            if (restart_s) begin
                addr_r  <= PROG_AW'(BASE_ADDR);
                count_r <= '0;
                full_r  <= 1'b0;
                err_r   <= 1'b0;
            end else if (write_s) begin
                im_addr_r  <= addr_r;
                im_wdata_r <= IW'(word_s);
                addr_r     <= addr_r + PROG_AW'(1);
                count_r    <= count_r + CNT_W'(1);
                full_r     <= last_s;
            end else if (accept_s) begin
                // Accepted but dropped: only the sticky error is recorded.
                err_r <= 1'b1;
            end else begin
                addr_r <= addr_r;
            end
        end
    end

    assign req_ready = ready_s;
    assign im_we     = im_we_r;
    assign im_addr   = im_addr_r;
    assign im_wdata  = im_wdata_r;
    assign count     = count_r;
    assign full      = full_r;
    assign err       = err_r;
    assign done      = done_r;

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed vector table, hand-written
// corner sequences and a randomized run against a behavioural model.
module tb_instr_encoder;

    localparam int AW  = 8;
    localparam int DEP = 4;
    localparam int CW  = AW + 1;

    logic          Clk = 1'b0;
    logic          Reset_n = 1'b0;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [2:0]    req_class = 3'd0;
    logic [1:0]    req_type = 2'd0;
    logic [5:0]    req_operand = 6'd0;
    logic          im_we;
    logic [AW-1:0] im_addr;
    logic [8:0]    im_wdata;
    logic [CW-1:0] count;
    logic          full;
    logic          err;
    logic          done;

    always #5 Clk = ~Clk;

    instr_encoder #(
        .IW(9), .PROG_AW(AW), .BASE_ADDR(0), .DEPTH(DEP)
    ) dut (
        .Clk(Clk), .Reset_n(Reset_n), .start(start), .stop(stop),
        .req_valid(req_valid), .req_ready(req_ready), .req_class(req_class),
        .req_type(req_type), .req_operand(req_operand), .im_we(im_we),
        .im_addr(im_addr), .im_wdata(im_wdata), .count(count), .full(full),
        .err(err), .done(done)
    );

    int total = 0;
    int bad = 0;

    typedef struct {
        logic       st, sp, v;
        logic [2:0] c;
        logic [1:0] t;
        logic [5:0] o;
        logic       rdy, we;
        int         addr, wd, cnt;
        logic       fl, dn;
    } vec_t;

    vec_t tbl[10];

    // behavioural model state
    int   m_mode;    // 0 idle, 1 running, 2 full
    int   m_addr, m_count;
    logic m_full, m_err;
    logic e_we, e_done;
    int   e_addr, e_wd;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", nm, act, exp);
        end
    endtask

    task automatic apply(input logic st, input logic sp, input logic v,
                         input logic [2:0] c, input logic [1:0] t, input logic [5:0] o);
        start = st; stop = sp; req_valid = v;
        req_class = c; req_type = t; req_operand = o;
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    function automatic int ref_word(input int c, input int t, input int o);
        if (c == 0 || c == 7) return c * 64 + t * 16 + (o % 16);
        else return c * 64 + o;
    endfunction

    function automatic logic ref_illegal(input int c, input int t, input int o);
`ifdef ENC_ILLEGAL_CHECK_EN
        return (c == 7 && t == 3) || (c == 6 && o != 0);
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_step(input logic st, input logic sp, input logic v,
                              input int c, input int t, input int o);
        logic rdy;
        rdy = (m_mode == 1) && !st && !sp;
        e_we = 1'b0;
        e_done = 1'b0;
        if (st) begin
            m_mode = 1; m_addr = 0; m_count = 0; m_full = 1'b0; m_err = 1'b0;
        end else if (sp && m_mode != 0) begin
            m_mode = 0; e_done = 1'b1;
        end else if (v && rdy) begin
            if (ref_illegal(c, t, o)) begin
                m_err = 1'b1;
            end else begin
                e_we = 1'b1; e_addr = m_addr; e_wd = ref_word(c, t, o);
                m_addr++; m_count++;
                if (m_count == DEP) begin
                    m_full = 1'b1; m_mode = 2;
                end
            end
        end
    endtask

    initial begin
        tbl[0] = '{1,0,0, 3'd0,2'd0,6'd0,  0,0, 0,0,    0, 0,0};
        tbl[1] = '{0,0,1, 3'd0,2'd1,6'd3,  1,1, 0,9'h013,1, 0,0};
        tbl[2] = '{1,0,1, 3'd1,2'd0,6'd5,  0,0, 0,0,    0, 0,0};
        tbl[3] = '{0,0,1, 3'd1,2'd2,6'd5,  1,1, 0,9'h045,1, 0,0};
        tbl[4] = '{0,0,1, 3'd2,2'd0,6'd1,  1,1, 1,9'h081,2, 0,0};
        tbl[5] = '{0,0,1, 3'd4,2'd0,6'd2,  1,1, 2,9'h102,3, 0,0};
        tbl[6] = '{0,0,1, 3'd5,2'd0,6'd3,  1,1, 3,9'h143,4, 1,0};
        tbl[7] = '{0,0,1, 3'd6,2'd0,6'd0,  0,0, 0,0,    4, 1,0};
        tbl[8] = '{0,1,0, 3'd0,2'd0,6'd0,  0,0, 0,0,    4, 1,1};
        tbl[9] = '{0,0,0, 3'd0,2'd0,6'd0,  0,0, 0,0,    4, 1,0};

        repeat (2) @(posedge Clk);
        #1;
        chk("rst_we", {31'd0, im_we}, 32'd0);
        chk("rst_addr", {24'd0, im_addr}, 32'd0);
        chk("rst_wdata", {23'd0, im_wdata}, 32'd0);
        chk("rst_count", {23'd0, count}, 32'd0);
        chk("rst_flags", {28'd0, full, err, done, req_ready}, 32'd0);
        Reset_n = 1'b1;
        tick();

        for (int i = 0; i < 10; i++) begin
            apply(tbl[i].st, tbl[i].sp, tbl[i].v, tbl[i].c, tbl[i].t, tbl[i].o);
            #3;
            chk($sformatf("tbl%0d_ready", i), {31'd0, req_ready}, {31'd0, tbl[i].rdy});
            tick();
            chk($sformatf("tbl%0d_we", i), {31'd0, im_we}, {31'd0, tbl[i].we});
            if (tbl[i].we) begin
                chk($sformatf("tbl%0d_addr", i), {24'd0, im_addr}, tbl[i].addr);
                chk($sformatf("tbl%0d_wdata", i), {23'd0, im_wdata}, tbl[i].wd);
            end
            chk($sformatf("tbl%0d_count", i), {23'd0, count}, tbl[i].cnt);
            chk($sformatf("tbl%0d_full", i), {31'd0, full}, {31'd0, tbl[i].fl});
            chk($sformatf("tbl%0d_done", i), {31'd0, done}, {31'd0, tbl[i].dn});
            chk($sformatf("tbl%0d_err", i), {31'd0, err}, 32'd0);
        end

        // illegal-request sequence
        apply(1, 0, 0, 3'd0, 2'd0, 6'd0);
        tick();
        apply(0, 0, 1, 3'd7, 2'd3, 6'd0);
        #3;
        chk("ill_ready", {31'd0, req_ready}, 32'd1);
        tick();
`ifdef ENC_ILLEGAL_CHECK_EN
        chk("ill1_we", {31'd0, im_we}, 32'd0);
        chk("ill1_err", {31'd0, err}, 32'd1);
        chk("ill1_count", {23'd0, count}, 32'd0);
`else
        chk("ill1_we", {31'd0, im_we}, 32'd1);
        chk("ill1_wdata", {23'd0, im_wdata}, 32'h1F0);
        chk("ill1_err", {31'd0, err}, 32'd0);
        chk("ill1_count", {23'd0, count}, 32'd1);
`endif
        apply(0, 0, 1, 3'd7, 2'd0, 6'd5);
        tick();
        chk("ill2_we", {31'd0, im_we}, 32'd1);
        chk("ill2_wdata", {23'd0, im_wdata}, 32'h1C5);
`ifdef ENC_ILLEGAL_CHECK_EN
        chk("ill2_addr", {24'd0, im_addr}, 32'd0);
        chk("ill2_err", {31'd0, err}, 32'd1);
`else
        chk("ill2_addr", {24'd0, im_addr}, 32'd1);
        chk("ill2_err", {31'd0, err}, 32'd0);
`endif
        apply(1, 0, 0, 3'd0, 2'd0, 6'd0);
        tick();
        chk("restart_err", {31'd0, err}, 32'd0);
        chk("restart_count", {23'd0, count}, 32'd0);

        // asynchronous reset while a write is on the port
        apply(0, 0, 1, 3'd4, 2'd0, 6'd7);
        tick();
        chk("pre_rst_we", {31'd0, im_we}, 32'd1);
        chk("pre_rst_wdata", {23'd0, im_wdata}, 32'h107);
        apply(0, 0, 0, 3'd0, 2'd0, 6'd0);
        #1;
        Reset_n = 1'b0;
        #1;
        chk("async_rst_we", {31'd0, im_we}, 32'd0);
        chk("async_rst_data", {15'd0, im_addr, im_wdata}, 32'd0);
        chk("async_rst_stat", {19'd0, count, full, err, done, req_ready}, 32'd0);
        @(posedge Clk);
        #2;
        Reset_n = 1'b1;
        tick();

        // randomized run against the model
        m_mode = 0; m_addr = 0; m_count = 0; m_full = 1'b0; m_err = 1'b0;
        for (int n = 0; n < 600; n++) begin
            logic st, sp, v, rdy;
            int c, t, o;
            st = ($urandom_range(0, 99) < 6);
            sp = ($urandom_range(0, 99) < 5);
            v  = ($urandom_range(0, 99) < 75);
            c  = $urandom_range(0, 7);
            t  = $urandom_range(0, 3);
            o  = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(0, 63);
            apply(st, sp, v, 3'(c), 2'(t), 6'(o));
            rdy = (m_mode == 1) && !st && !sp;
            #3;
            chk("rnd_ready", {31'd0, req_ready}, {31'd0, rdy});
            model_step(st, sp, v, c, t, o);
            tick();
            chk("rnd_we", {31'd0, im_we}, {31'd0, e_we});
            if (e_we) begin
                chk("rnd_addr", {24'd0, im_addr}, e_addr);
                chk("rnd_wdata", {23'd0, im_wdata}, e_wd);
            end
            chk("rnd_count", {23'd0, count}, m_count);
            chk("rnd_flags", {29'd0, full, err, done}, {29'd0, m_full, m_err, e_done});
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
